// File: rtl/multiplier_unit.sv
// multiplier_unit: unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
// A partial-product AND array is reduced by WIDTH-1 ripple-carry adder rows
// made of half/full-adder cells. The product is registered with a valid flag,
// giving one cycle of latency.
module multiplier_unit #(
   parameter int WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 out_valid,
   output logic [2*WIDTH-1:0]   P
);

   // Half-adder cell: returns {carry, sum}.
   function automatic logic [1:0] ha_cell(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   // Full-adder cell: returns {carry, sum}.
   function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic ci);
      return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

   // pp[i][j] = A[j] & B[i]; row i carries weight 2^i.
   logic [WIDTH-1:0] pp [WIDTH];

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp_row
         for (genvar gj = 0; gj < WIDTH; gj++) begin : g_pp_col
            assign pp[gi][gj] = A[gj] & B[gi];
         end
      end
   endgenerate

   logic [2*WIDTH-1:0] product_comb;
   logic [WIDTH-1:0]   low_bits;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   row_sum;
   logic               acc_top;
   logic               ripple;
   logic [1:0]         cell_out;

   // Adder array: each row adds the next partial product to the running sum
   // shifted right by one; the row's LSB retires into the product low bits.
   always_comb begin
      low_bits     = '0;
      acc          = pp[0];
      acc_top      = 1'b0;
      addend       = '0;
      row_sum      = '0;
      ripple       = 1'b0;
      cell_out     = '0;
      low_bits[0]  = pp[0][0];
      for (int i = 1; i < WIDTH; i++) begin
         addend = {acc_top, acc[WIDTH-1:1]};
         ripple = 1'b0;
         for (int j = 0; j < WIDTH; j++) begin
            if (j == 0) begin
               cell_out = ha_cell(pp[i][j], addend[j]);
            end else begin
               cell_out = fa_cell(pp[i][j], addend[j], ripple);
            end
            row_sum[j] = cell_out[0];
            ripple     = cell_out[1];
         end
         acc         = row_sum;
         acc_top     = ripple;
         low_bits[i] = row_sum[0];
      end
      product_comb = {acc_top, acc[WIDTH-1:1], low_bits};
   end

   logic [2*WIDTH-1:0] p_q, p_d;
   logic               valid_q, valid_d;

   // Next state: capture only when the operands are valid, otherwise hold P.
   always_comb begin
      valid_d = in_valid;
      p_d     = in_valid ? product_comb : p_q;
   end

   // Output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         p_q     <= p_d;
         valid_q <= valid_d;
      end
   end

   assign P         = p_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_multiplier_unit.sv
// Directed testbench for multiplier_unit at WIDTH=2 and WIDTH=8.
module tb_multiplier_unit;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid2;
   logic [1:0]  a2, b2;
   logic        out_valid2;
   logic [3:0]  p2;

   logic        in_valid8;
   logic [7:0]  a8, b8;
   logic        out_valid8;
   logic [15:0] p8;

   int tests = 0;
   int fails = 0;

   multiplier_unit #(.WIDTH(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid2),
      .A         (a2),
      .B         (b2),
      .out_valid (out_valid2),
      .P         (p2)
   );

   multiplier_unit #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .A         (a8),
      .B         (b8),
      .out_valid (out_valid8),
      .P         (p8)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply one WIDTH=2 pair, clock it, check product and valid.
   task automatic run2(input string tag, input logic [1:0] a, input logic [1:0] b,
                       input logic [3:0] exp);
      in_valid2 = 1'b1;
      a2 = a;
      b2 = b;
      tick();
      check(tag, {12'd0, p2}, {12'd0, exp});
      check({tag, "_valid"}, {15'd0, out_valid2}, 16'd1);
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp);
      in_valid8 = 1'b1;
      a8 = a;
      b8 = b;
      tick();
      check(tag, p8, exp);
      check({tag, "_valid"}, {15'd0, out_valid8}, 16'd1);
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic [15:0] rexp;

      rst_n = 1'b0;
      in_valid2 = 1'b1; a2 = 2'd3; b2 = 2'd3;
      in_valid8 = 1'b1; a8 = 8'd255; b8 = 8'd255;

      // Reset held: outputs stay cleared while operands toggle.
      tick();
      check("rst_p2_a", {12'd0, p2}, 16'd0);
      check("rst_v2_a", {15'd0, out_valid2}, 16'd0);
      check("rst_p8_a", p8, 16'd0);
      a2 = 2'd2; b2 = 2'd1; a8 = 8'd17;
      tick();
      check("rst_p2_b", {12'd0, p2}, 16'd0);
      check("rst_v2_b", {15'd0, out_valid2}, 16'd0);
      check("rst_v8_b", {15'd0, out_valid8}, 16'd0);

      // Release between edges; first capture is 2*3.
      in_valid8 = 1'b0;
      #3 rst_n = 1'b1;
      run2("first_2x3", 2'd2, 2'd3, 4'd6);

      // Back-to-back directed sequence.
      run2("seq_2x3", 2'd2, 2'd3, 4'd6);
      run2("seq_2x1", 2'd2, 2'd1, 4'd2);
      run2("seq_3x3", 2'd3, 2'd3, 4'd9);
      run2("seq_1x1", 2'd1, 2'd1, 4'd1);
      run2("seq_3x1", 2'd3, 2'd1, 4'd3);
      run2("seq_1x3", 2'd1, 2'd3, 4'd3);
      run2("seq_3x2", 2'd3, 2'd2, 4'd6);
      run2("seq_2x2", 2'd2, 2'd2, 4'd4);

      // Exhaustive WIDTH=2 against the integer product.
      for (int ia = 0; ia < 4; ia++) begin
         for (int ib = 0; ib < 4; ib++) begin
            run2($sformatf("exh_%0dx%0d", ia, ib), 2'(ia), 2'(ib), 4'(ia * ib));
         end
      end

      // Hold: in_valid low keeps P and drops out_valid, even with X operands.
      run2("hold_load", 2'd3, 2'd3, 4'd9);
      in_valid2 = 1'b0; a2 = 2'd1; b2 = 2'd1;
      tick();
      check("hold_p", {12'd0, p2}, 16'd9);
      check("hold_v", {15'd0, out_valid2}, 16'd0);
      a2 = 2'bxx; b2 = 2'bxx;
      tick();
      check("hold_x_p", {12'd0, p2}, 16'd9);
      check("hold_x_v", {15'd0, out_valid2}, 16'd0);

      // Asynchronous reset mid-stream, observed before any clock edge.
      run2("arst_load", 2'd3, 2'd3, 4'd9);
      #2 rst_n = 1'b0;
      #1;
      check("arst_p", {12'd0, p2}, 16'd0);
      check("arst_v", {15'd0, out_valid2}, 16'd0);
      in_valid2 = 1'b0; a2 = 2'd3; b2 = 2'd2;
      #2 rst_n = 1'b1;
      tick();
      check("post_rst_idle_p", {12'd0, p2}, 16'd0);
      check("post_rst_idle_v", {15'd0, out_valid2}, 16'd0);
      run2("post_rst_3x2", 2'd3, 2'd2, 4'd6);
      in_valid2 = 1'b0;

      // WIDTH=8 boundaries and random pairs.
      run8("w8_255x255", 8'd255, 8'd255, 16'd65025);
      run8("w8_128x2",   8'd128, 8'd2,   16'd256);
      run8("w8_0x200",   8'd0,   8'd200, 16'd0);
      run8("w8_200x0",   8'd200, 8'd0,   16'd0);
      in_valid8 = 1'b0; a8 = 8'd1; b8 = 8'd1;
      tick();
      check("w8_hold_p", p8, 16'd0);
      check("w8_hold_v", {15'd0, out_valid8}, 16'd0);
      for (int k = 0; k < 1000; k++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rexp = 16'(ra) * 16'(rb);
         run8($sformatf("w8_rand_%0dx%0d", ra, rb), ra, rb, rexp);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
